// File: rtl/lsu_mem_stage_pkg.sv
// Shared opcodes, func3 encodings, trap causes and FSM state type for the LSU memory stage.
package lsu_mem_stage_pkg;

   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;

   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;

   localparam logic [3:0] CAUSE_ILLEGAL     = 4'd2;
   localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
   localparam logic [3:0] CAUSE_LD_FAULT    = 4'd5;
   localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;
   localparam logic [3:0] CAUSE_ST_FAULT    = 4'd7;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StReq  = 2'd1,
      StWait = 2'd2
   } lsu_state_e;

   function automatic logic f3_illegal(input logic is_store, input logic [2:0] f3);
      if (is_store) begin
         return f3 >= 3'd3;
      end
      return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
   endfunction

endpackage

// File: rtl/lsu_mem_stage_align.sv
// Byte-lane steering: store strobes/replicated data, load extraction/extension, misalignment.
module lsu_mem_stage_align
   import lsu_mem_stage_pkg::*;
(
   input  logic [2:0]  func3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] st_data,
   input  logic [31:0] rd_word,
   output logic [3:0]  wstrb,
   output logic [31:0] wdata,
   output logic [31:0] ld_data,
   output logic        misaligned
);

   logic [31:0] shifted;

   always_comb begin
      shifted    = rd_word >> {addr_lo, 3'b000};
      wstrb      = 4'b1111;
      wdata      = st_data;
      ld_data    = rd_word;
      misaligned = 1'b0;
      unique case (func3[1:0])
         2'b00: begin
            wstrb   = 4'b0001 << addr_lo;
            wdata   = {4{st_data[7:0]}};
            ld_data = func3[2] ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
         end
         2'b01: begin
            wstrb      = 4'b0011 << {addr_lo[1], 1'b0};
            wdata      = {2{st_data[15:0]}};
            ld_data    = func3[2] ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            misaligned = addr_lo[0];
         end
         default: begin
            misaligned = |addr_lo;
         end
      endcase
   end

endmodule

// File: rtl/lsu_mem_stage.sv
// Memory stage: runs loads/stores against the dmem port, passes other ops to write-back,
// stalls the core while an access is outstanding and raises traps on bad or stuck accesses.
module lsu_mem_stage
   import lsu_mem_stage_pkg::*;
#(
   parameter int unsigned TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_vld,
   input  logic [31:0] i_result,
   input  logic [31:0] i_data_store,
   input  logic [31:0] i_pc,
   input  logic [2:0]  i_func3,
   input  logic [6:0]  i_opcode,
   input  logic [4:0]  i_rd,
   output logic        o_stall,
   output logic        o_dmem_req,
   output logic        o_dmem_we,
   output logic [31:0] o_dmem_addr,
   output logic [31:0] o_dmem_wdata,
   output logic [3:0]  o_dmem_wstrb,
   input  logic        i_dmem_rdy,
   input  logic        i_dmem_vld,
   input  logic [31:0] i_dmem_rdata,
   output logic        o_wb_vld,
   output logic [31:0] o_wb_data,
   output logic [4:0]  o_wb_rd,
   output logic [31:0] o_wb_pc,
   output logic        o_trap,
   output logic [3:0]  o_trap_cause,
   output logic [31:0] o_trap_pc
);

   localparam int unsigned CntW = $clog2(TIMEOUT + 1);

   lsu_state_e  state_q, state_d;
   logic [31:0] addr_q, addr_d, data_q, data_d, pc_q, pc_d;
   logic [2:0]  f3_q, f3_d;
   logic [4:0]  rd_q, rd_d;
   logic        store_q, store_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic        wb_vld_q, wb_vld_d, trap_q, trap_d;
   logic [31:0] wb_data_q, wb_data_d;
   logic [3:0]  cause_q, cause_d;

   logic        idle, is_ld, is_st, timed_out, misaligned;
   logic [3:0]  al_wstrb;
   logic [31:0] al_wdata, al_ld_data;

   assign idle      = (state_q == StIdle);
   assign is_ld     = (i_opcode == OPC_LOAD);
   assign is_st     = (i_opcode == OPC_STORE);
   assign timed_out = (cnt_q == CntW'(TIMEOUT - 1));

   // In IDLE the aligner checks the incoming op; otherwise it serves the captured one.
   lsu_mem_stage_align u_align (
      .func3      (idle ? i_func3 : f3_q),
      .addr_lo    (idle ? i_result[1:0] : addr_q[1:0]),
      .st_data    (data_q),
      .rd_word    (i_dmem_rdata),
      .wstrb      (al_wstrb),
      .wdata      (al_wdata),
      .ld_data    (al_ld_data),
      .misaligned (misaligned)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         addr_q    <= '0;
         data_q    <= '0;
         pc_q      <= '0;
         f3_q      <= '0;
         rd_q      <= '0;
         store_q   <= 1'b0;
         cnt_q     <= '0;
         wb_vld_q  <= 1'b0;
         wb_data_q <= '0;
         trap_q    <= 1'b0;
         cause_q   <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         pc_q      <= pc_d;
         f3_q      <= f3_d;
         rd_q      <= rd_d;
         store_q   <= store_d;
         cnt_q     <= cnt_d;
         wb_vld_q  <= wb_vld_d;
         wb_data_q <= wb_data_d;
         trap_q    <= trap_d;
         cause_q   <= cause_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      data_d    = data_q;
      pc_d      = pc_q;
      f3_d      = f3_q;
      rd_d      = rd_q;
      store_d   = store_q;
      cnt_d     = cnt_q;
      wb_vld_d  = 1'b0;
      wb_data_d = wb_data_q;
      trap_d    = 1'b0;
      cause_d   = cause_q;
      unique case (state_q)
         StIdle: begin
            if (i_vld) begin
               addr_d  = i_result;
               data_d  = i_data_store;
               pc_d    = i_pc;
               f3_d    = i_func3;
               rd_d    = i_rd;
               store_d = is_st;
               if (!is_ld && !is_st) begin
                  wb_vld_d  = 1'b1;
                  wb_data_d = i_result;
               end else if (f3_illegal(is_st, i_func3)) begin
                  trap_d  = 1'b1;
                  cause_d = CAUSE_ILLEGAL;
               end else if (misaligned) begin
                  trap_d  = 1'b1;
                  cause_d = is_st ? CAUSE_ST_MISALIGN : CAUSE_LD_MISALIGN;
               end else begin
                  state_d = StReq;
                  cnt_d   = '0;
               end
            end
         end
         StReq, StWait: begin
            // Timeout takes priority over a coincident rdy/vld.
            if (timed_out) begin
               trap_d  = 1'b1;
               cause_d = store_q ? CAUSE_ST_FAULT : CAUSE_LD_FAULT;
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (state_q == StReq && i_dmem_rdy) begin
                  state_d = store_q ? StIdle : StWait;
               end else if (state_q == StWait && i_dmem_vld) begin
                  wb_vld_d  = 1'b1;
                  wb_data_d = al_ld_data;
                  state_d   = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      o_stall      = !idle;
      o_dmem_req   = (state_q == StReq);
      o_dmem_we    = o_dmem_req & store_q;
      o_dmem_addr  = o_dmem_req ? {addr_q[31:2], 2'b00} : 32'b0;
      o_dmem_wdata = o_dmem_we ? al_wdata : 32'b0;
      o_dmem_wstrb = o_dmem_we ? al_wstrb : 4'b0;
      o_wb_vld     = wb_vld_q;
      o_wb_data    = wb_data_q;
      o_wb_rd      = rd_q;
      o_wb_pc      = pc_q;
      o_trap       = trap_q;
      o_trap_cause = cause_q;
      o_trap_pc    = pc_q;
   end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Scoreboard bench for lsu_mem_stage: stimulus pushes expected wb/trap events, a negedge
// monitor pops and compares them whenever the DUT strobes o_wb_vld or o_trap.
module tb_lsu_mem_stage;
   import lsu_mem_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_vld = 1'b0;
   logic [31:0] i_result = '0, i_data_store = '0, i_pc = '0;
   logic [2:0]  i_func3 = '0;
   logic [6:0]  i_opcode = '0;
   logic [4:0]  i_rd = '0;
   logic        o_stall, o_dmem_req, o_dmem_we;
   logic [31:0] o_dmem_addr, o_dmem_wdata;
   logic [3:0]  o_dmem_wstrb;
   logic        i_dmem_rdy = 1'b0, i_dmem_vld = 1'b0;
   logic [31:0] i_dmem_rdata = '0;
   logic        o_wb_vld, o_trap;
   logic [31:0] o_wb_data, o_wb_pc, o_trap_pc;
   logic [4:0]  o_wb_rd;
   logic [3:0]  o_trap_cause;

   localparam logic [6:0] OPC_ADD = 7'b0110011;

   always #5 clk = ~clk;

   lsu_mem_stage #(.TIMEOUT(8)) dut (
      .clk(clk), .rst(rst), .i_vld(i_vld), .i_result(i_result), .i_data_store(i_data_store),
      .i_pc(i_pc), .i_func3(i_func3), .i_opcode(i_opcode), .i_rd(i_rd), .o_stall(o_stall),
      .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
      .o_dmem_wdata(o_dmem_wdata), .o_dmem_wstrb(o_dmem_wstrb), .i_dmem_rdy(i_dmem_rdy),
      .i_dmem_vld(i_dmem_vld), .i_dmem_rdata(i_dmem_rdata), .o_wb_vld(o_wb_vld),
      .o_wb_data(o_wb_data), .o_wb_rd(o_wb_rd), .o_wb_pc(o_wb_pc), .o_trap(o_trap),
      .o_trap_cause(o_trap_cause), .o_trap_pc(o_trap_pc)
   );

   typedef struct {
      logic        is_trap;
      logic [31:0] data;
      logic [4:0]  rd;
      logic [31:0] pc;
      logic [3:0]  cause;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0, n_fail = 0;
   int   stall_cnt = 0, req_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor
   always @(negedge clk) begin
      exp_t e;
      if (o_stall) stall_cnt++;
      if (o_dmem_req) req_cnt++;
      if (o_wb_vld || o_trap) begin
         chk("wb_trap_exclusive", {31'b0, o_wb_vld & o_trap}, 32'b0);
         if (exp_q.size() == 0) begin
            chk("unexpected_event", {31'b0, o_trap}, {31'b0, ~o_trap});
            chk("unexpected_event_count", 32'd1, 32'd0 + 32'(exp_q.size()));
         end else begin
            e = exp_q.pop_front();
            chk("event_kind", {31'b0, o_trap}, {31'b0, e.is_trap});
            if (e.is_trap) begin
               chk("trap_cause", {28'b0, o_trap_cause}, {28'b0, e.cause});
               chk("trap_pc", o_trap_pc, e.pc);
            end else begin
               chk("wb_data", o_wb_data, e.data);
               chk("wb_rd", {27'b0, o_wb_rd}, {27'b0, e.rd});
               chk("wb_pc", o_wb_pc, e.pc);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_wb(input logic [31:0] data, input logic [4:0] rd, input logic [31:0] pc);
      exp_t e;
      e.is_trap = 1'b0; e.data = data; e.rd = rd; e.pc = pc; e.cause = '0;
      exp_q.push_back(e);
   endtask

   task automatic push_trap(input logic [3:0] cause, input logic [31:0] pc);
      exp_t e;
      e.is_trap = 1'b1; e.data = '0; e.rd = '0; e.pc = pc; e.cause = cause;
      exp_q.push_back(e);
   endtask

   task automatic issue(input logic [6:0] opc, input logic [2:0] f3, input logic [31:0] res,
                        input logic [31:0] dat, input logic [31:0] pc, input logic [4:0] rd);
      i_vld = 1'b1; i_opcode = opc; i_func3 = f3; i_result = res;
      i_data_store = dat; i_pc = pc; i_rd = rd;
      tick();
      i_vld = 1'b0; i_result = 32'hDEAD_0000; i_data_store = 32'hDEAD_1111;
   endtask

   task automatic store_op(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] dat,
                           input int rdy_dly, input logic [31:0] e_addr, input logic [3:0] e_strb,
                           input logic [31:0] e_wdata);
      issue(OPC_STORE, f3, addr, dat, 32'h2000 + addr, 5'd0);
      for (int i = 0; i <= rdy_dly; i++) begin
         chk("st_req", {31'b0, o_dmem_req}, 32'd1);
         chk("st_addr", o_dmem_addr, e_addr);
         if (i == rdy_dly) begin
            chk("st_we", {31'b0, o_dmem_we}, 32'd1);
            chk("st_wstrb", {28'b0, o_dmem_wstrb}, {28'b0, e_strb});
            chk("st_wdata", o_dmem_wdata, e_wdata);
            i_dmem_rdy = 1'b1;
         end
         tick();
      end
      i_dmem_rdy = 1'b0;
   endtask

   task automatic load_op(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd,
                          input int rdy_dly, input int vld_dly, input logic [31:0] rdata,
                          input logic [31:0] e_data);
      push_wb(e_data, rd, 32'h3000 + addr);
      issue(OPC_LOAD, f3, addr, 32'h0, 32'h3000 + addr, rd);
      chk("ld_req", {31'b0, o_dmem_req}, 32'd1);
      chk("ld_we", {31'b0, o_dmem_we}, 32'd0);
      chk("ld_addr", o_dmem_addr, {addr[31:2], 2'b00});
      repeat (rdy_dly) tick();
      i_dmem_rdy = 1'b1;
      tick();
      i_dmem_rdy = 1'b0;
      repeat (vld_dly) tick();
      i_dmem_vld = 1'b1; i_dmem_rdata = rdata;
      tick();
      i_dmem_vld = 1'b0; i_dmem_rdata = 32'h5A5A_5A5A;
      tick();
   endtask

   initial begin
      int s0, r0;
      repeat (3) tick();
      rst = 1'b0;
      chk("rst_stall", {31'b0, o_stall}, 32'd0);
      chk("rst_req", {31'b0, o_dmem_req}, 32'd0);
      chk("rst_wb_vld", {31'b0, o_wb_vld}, 32'd0);
      chk("rst_trap", {31'b0, o_trap}, 32'd0);
      // stray response while idle must be ignored
      i_dmem_vld = 1'b1; i_dmem_rdata = 32'h1234_5678;
      tick();
      i_dmem_vld = 1'b0;
      tick();

      // 1) pass-through add
      s0 = stall_cnt;
      push_wb(32'h1234, 5'd4, 32'h1000);
      issue(OPC_ADD, 3'd0, 32'h1234, 32'h0, 32'h1000, 5'd4);
      tick();
      chk("add_stall_cycles", 32'(stall_cnt - s0), 32'd0);

      // 2) stores
      s0 = stall_cnt; r0 = req_cnt;
      store_op(F3_B, 32'h103, 32'hAB, 2, 32'h100, 4'b1000, 32'hABAB_ABAB);
      tick();
      chk("sb_stall_cycles", 32'(stall_cnt - s0), 32'd3);
      chk("sb_req_cycles", 32'(req_cnt - r0), 32'd3);
      store_op(F3_H, 32'h202, 32'h1234_CDEF, 0, 32'h200, 4'b1100, 32'hCDEF_CDEF);
      store_op(F3_W, 32'h300, 32'hCAFE_F00D, 1, 32'h300, 4'b1111, 32'hCAFE_F00D);
      tick();

      // 3) loads
      load_op(F3_B,  32'h102, 5'd5, 0, 0, 32'h0080_0000, 32'hFFFF_FF80);
      load_op(F3_BU, 32'h102, 5'd6, 1, 2, 32'h0080_0000, 32'h0000_0080);
      load_op(F3_H,  32'h102, 5'd7, 0, 1, 32'h8001_0000, 32'hFFFF_8001);
      load_op(F3_HU, 32'h100, 5'd0, 0, 0, 32'h1234_F00F, 32'h0000_F00F);
      load_op(F3_W,  32'h104, 5'd9, 2, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

      // 4) misaligned / illegal
      r0 = req_cnt;
      push_trap(CAUSE_LD_MISALIGN, 32'h4000);
      issue(OPC_LOAD, F3_W, 32'h101, 32'h0, 32'h4000, 5'd1);
      tick();
      push_trap(CAUSE_ST_MISALIGN, 32'h4004);
      issue(OPC_STORE, F3_H, 32'h3, 32'h0, 32'h4004, 5'd0);
      tick();
      push_trap(CAUSE_ILLEGAL, 32'h4008);
      issue(OPC_LOAD, 3'd7, 32'h100, 32'h0, 32'h4008, 5'd2);
      tick();
      push_trap(CAUSE_ILLEGAL, 32'h400C);
      issue(OPC_STORE, 3'd3, 32'h100, 32'h0, 32'h400C, 5'd0);
      tick();
      chk("bad_op_req_cycles", 32'(req_cnt - r0), 32'd0);

      // 5) load timeout; a late vld must not write back
      s0 = stall_cnt;
      push_trap(CAUSE_LD_FAULT, 32'h5000);
      issue(OPC_LOAD, F3_W, 32'h400, 32'h0, 32'h5000, 5'd3);
      i_dmem_rdy = 1'b1;
      tick();
      i_dmem_rdy = 1'b0;
      repeat (10) tick();
      chk("timeout_stall_cycles", 32'(stall_cnt - s0), 32'd8);
      i_dmem_vld = 1'b1; i_dmem_rdata = 32'h1111_2222;
      tick();
      i_dmem_vld = 1'b0;
      tick();
      chk("timeout_queue_empty", 32'(exp_q.size()), 32'd0);

      // 6) reset while waiting for load data
      issue(OPC_LOAD, F3_W, 32'h500, 32'h0, 32'h6000, 5'd8);
      i_dmem_rdy = 1'b1;
      tick();
      i_dmem_rdy = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_stall", {31'b0, o_stall}, 32'd0);
      chk("mid_rst_req", {31'b0, o_dmem_req}, 32'd0);
      chk("mid_rst_addr", o_dmem_addr, 32'd0);
      chk("mid_rst_wb_data", o_wb_data, 32'd0);
      chk("mid_rst_wb_pc", o_wb_pc, 32'd0);
      chk("mid_rst_trap_pc", o_trap_pc, 32'd0);
      i_dmem_vld = 1'b1; i_dmem_rdata = 32'h7777_8888;
      tick();
      i_dmem_vld = 1'b0;
      tick();
      push_wb(32'hA5A5_0001, 5'd10, 32'h6100);
      issue(OPC_ADD, 3'd0, 32'hA5A5_0001, 32'h0, 32'h6100, 5'd10);
      repeat (2) tick();

      chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
